// File: rtl/redmule_tile_tcdm_mem_if.sv
// Initiator-side bus of the tile TCDM: one request/response channel per port.
interface redmule_tile_tcdm_mem_if #(
    parameter int N_PORTS = 2,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32
) ();
    logic [N_PORTS-1:0]                req_i;
    logic [N_PORTS-1:0]                gnt_o;
    logic [N_PORTS-1:0][ADDR_W-1:0]    addr_i;
    logic [N_PORTS-1:0]                we_i;
    logic [N_PORTS-1:0][DATA_W/8-1:0]  be_i;
    logic [N_PORTS-1:0][DATA_W-1:0]    wdata_i;
    logic [N_PORTS-1:0]                r_valid_o;
    logic [N_PORTS-1:0][DATA_W-1:0]    r_rdata_o;
    logic [N_PORTS-1:0]                r_err_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, r_valid_o, r_rdata_o, r_err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, r_valid_o, r_rdata_o, r_err_o
    );
endinterface

// File: rtl/redmule_tile_tcdm_mem.sv
// Multi-port word-interleaved tile memory. Each bank owns a round-robin
// arbiter and a single-ported array; responses come back one cycle after grant.

// One bank: arbitrates among ports that target it and performs one access.
module redmule_tile_tcdm_mem_bank #(
    parameter int N_PORTS      = 2,
    parameter int N_WORDS_BANK = 1024,
    parameter int DATA_W       = 32,
    parameter int PTR_W        = 1,
    parameter int ROW_W        = 10
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [N_PORTS-1:0]                 i_req,
    input  logic [N_PORTS-1:0]                 i_we,
    input  logic [N_PORTS-1:0]                 i_oor,
    input  logic [N_PORTS-1:0][ROW_W-1:0]      i_row,
    input  logic [N_PORTS-1:0][DATA_W/8-1:0]   i_be,
    input  logic [N_PORTS-1:0][DATA_W-1:0]     i_wdata,
    output logic [N_PORTS-1:0]                 o_gnt,
    output logic [DATA_W-1:0]                  o_rdata
);
    logic [PTR_W-1:0]  r_rr;
    logic [DATA_W-1:0] r_mem [N_WORDS_BANK];
    logic [DATA_W-1:0] r_rdata;
    logic              w_any;
    logic [PTR_W-1:0]  w_win;
    logic [PTR_W-1:0]  w_idx;

    // Pick the first requester at or after the priority pointer, wrapping.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        o_gnt = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            w_idx = PTR_W'((int'(r_rr) + k) % N_PORTS);
            if (!w_any && i_req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
        if (w_any) o_gnt[w_win] = 1'b1;
    end

    // Pointer moves just past the winner; an idle bank keeps its pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i)      r_rr <= '0;
        else if (w_any) r_rr <= PTR_W'((int'(w_win) + 1) % N_PORTS);
    end

    // Byte-masked write; out-of-range rows alias real rows so they must not land.
    always_ff @(posedge clk_i) begin
        if (w_any && i_we[w_win] && !i_oor[w_win]) begin
            for (int i = 0; i < DATA_W/8; i++)
                if (i_be[w_win][i]) r_mem[i_row[w_win]][8*i +: 8] <= i_wdata[w_win][8*i +: 8];
        end
    end

    // Read captures the pre-write word; the top masks it for writes and errors.
    always_ff @(posedge clk_i) begin
        if (w_any && !i_we[w_win]) r_rdata <= r_mem[i_row[w_win]];
    end

    assign o_rdata = r_rdata;
endmodule

// Top: address decode, bank fan-out, grant merge and response steering.
module redmule_tile_tcdm_mem #(
    parameter int N_PORTS      = 2,
    parameter int N_MEM_BANKS  = 16,
    parameter int N_WORDS_BANK = 1024,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32
) (
    input logic                      clk_i,
    input logic                      rst_i,
    redmule_tile_tcdm_mem_if.slave   tcdm
);
    // Assumes at least two banks and that the address covers bank+row bits.
    localparam int BANK_W = $clog2(N_MEM_BANKS);
    localparam int ROW_W  = $clog2(N_WORDS_BANK);
    localparam int PTR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int RF_W   = ADDR_W - 2 - BANK_W;

    logic [N_PORTS-1:0][BANK_W-1:0]      w_bank;
    logic [N_PORTS-1:0][ROW_W-1:0]       w_row;
    logic [N_PORTS-1:0]                  w_oor;
    logic [N_MEM_BANKS-1:0][N_PORTS-1:0] w_breq;
    logic [N_MEM_BANKS-1:0][N_PORTS-1:0] w_bgnt;
    logic [N_MEM_BANKS-1:0][DATA_W-1:0]  w_brdata;
    logic [N_PORTS-1:0]                  w_gnt;
    logic [N_PORTS-1:0][DATA_W-1:0]      w_rdata;
    logic [N_PORTS-1:0][1:0]             w_unused_lsb;
    logic                                w_unused;

    logic [N_PORTS-1:0]                  r_valid;
    logic [N_PORTS-1:0]                  r_we;
    logic [N_PORTS-1:0]                  r_err;
    logic [N_PORTS-1:0][BANK_W-1:0]      r_bank;

    genvar gp, gb;
    generate
        for (gp = 0; gp < N_PORTS; gp++) begin : g_dec
            assign w_bank[gp]       = tcdm.addr_i[gp][2 +: BANK_W];
            assign w_row[gp]        = tcdm.addr_i[gp][2+BANK_W +: ROW_W];
            assign w_unused_lsb[gp] = tcdm.addr_i[gp][1:0];
            if (RF_W > ROW_W) begin : g_oor
                assign w_oor[gp] = |tcdm.addr_i[gp][ADDR_W-1:2+BANK_W+ROW_W];
            end else begin : g_no_oor
                assign w_oor[gp] = 1'b0;
            end
        end
    endgenerate

    // Byte offset within the word never affects the access.
    assign w_unused = ^w_unused_lsb;

    // Steer each port's request to its bank; reset blocks every request.
    always_comb begin
        w_breq = '0;
        for (int b = 0; b < N_MEM_BANKS; b++)
            for (int p = 0; p < N_PORTS; p++)
                w_breq[b][p] = tcdm.req_i[p] && !rst_i && (w_bank[p] == BANK_W'(b));
    end

    generate
        for (gb = 0; gb < N_MEM_BANKS; gb++) begin : g_bank
            redmule_tile_tcdm_mem_bank #(
                .N_PORTS      (N_PORTS),
                .N_WORDS_BANK (N_WORDS_BANK),
                .DATA_W       (DATA_W),
                .PTR_W        (PTR_W),
                .ROW_W        (ROW_W)
            ) u_bank (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .i_req   (w_breq[gb]),
                .i_we    (tcdm.we_i),
                .i_oor   (w_oor),
                .i_row   (w_row),
                .i_be    (tcdm.be_i),
                .i_wdata (tcdm.wdata_i),
                .o_gnt   (w_bgnt[gb]),
                .o_rdata (w_brdata[gb])
            );
        end
    endgenerate

    // A port can win in at most one bank, so OR-merging is exact.
    always_comb begin
        w_gnt = '0;
        for (int b = 0; b < N_MEM_BANKS; b++) w_gnt = w_gnt | w_bgnt[b];
    end

    // Remember what each granted access needs to shape its response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_we    <= '0;
            r_err   <= '0;
            r_bank  <= '0;
        end else begin
            r_valid <= w_gnt;
            r_we    <= tcdm.we_i;
            r_err   <= w_oor;
            r_bank  <= w_bank;
        end
    end

    // Only valid, in-range reads return bank data; everything else is zero.
    always_comb begin
        w_rdata = '0;
        for (int p = 0; p < N_PORTS; p++)
            if (r_valid[p] && !r_we[p] && !r_err[p]) w_rdata[p] = w_brdata[r_bank[p]];
    end

    assign tcdm.gnt_o     = w_gnt;
    assign tcdm.r_valid_o = r_valid;
    assign tcdm.r_err_o   = r_valid & r_err;
    assign tcdm.r_rdata_o = w_rdata;
endmodule

// File: tb/tb_redmule_tile_tcdm_mem.sv
// Bench for the tile TCDM: directed vector table, reset corner sequence,
// then random traffic scored against a word-level memory/arbitration model.
module tb_redmule_tile_tcdm_mem;
    localparam int NP = 2, NB = 16, NW = 1024, DW = 32, AW = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    redmule_tile_tcdm_mem_if #(.N_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) bus ();

    redmule_tile_tcdm_mem #(
        .N_PORTS(NP), .N_MEM_BANKS(NB), .N_WORDS_BANK(NW), .DATA_W(DW), .ADDR_W(AW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .tcdm  (bus)
    );

    // Expected response for the cycle after the current one.
    logic [1:0]       e_rv, e_err, e_chk;
    logic [1:0][31:0] e_rd;

    typedef struct {
        logic [1:0]  req, we;
        logic [31:0] a0, a1;
        logic [3:0]  b0, b1;
        logic [31:0] d0, d1;
        logic [1:0]  gnt;
        logic [31:0] r0, r1;
        logic [1:0]  chk, err;
    } vec_t;

    typedef struct {
        bit          act;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } pend_t;

    vec_t        tbl [15];
    logic [31:0] mem_m [int];
    int          rr_m [NB];
    pend_t       pd [NP];

    function automatic vec_t mk(input logic [1:0] req, we, input logic [31:0] a0, a1,
                                input logic [3:0] b0, b1, input logic [31:0] d0, d1,
                                input logic [1:0] gnt, input logic [31:0] r0, r1,
                                input logic [1:0] chk, err);
        vec_t v;
        v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.b0 = b0; v.b1 = b1;
        v.d0 = d0; v.d1 = d1; v.gnt = gnt; v.r0 = r0; v.r1 = r1; v.chk = chk; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_resp(input string tag);
        chk({tag, " r_valid"}, 32'(bus.r_valid_o), 32'(e_rv));
        chk({tag, " r_err"}, 32'(bus.r_err_o), 32'(e_err & e_rv));
        for (int p = 0; p < NP; p++)
            if (!e_rv[p] || e_chk[p])
                chk($sformatf("%s r_rdata[%0d]", tag, p), bus.r_rdata_o[p], e_rv[p] ? e_rd[p] : 32'h0);
    endtask

    task automatic drive(input logic [1:0] req, we, input logic [31:0] a0, a1,
                         input logic [3:0] b0, b1, input logic [31:0] d0, d1);
        bus.req_i = req;
        bus.we_i = we;
        bus.addr_i[0] = a0;  bus.addr_i[1] = a1;
        bus.be_i[0] = b0;    bus.be_i[1] = b1;
        bus.wdata_i[0] = d0; bus.wdata_i[1] = d1;
    endtask

    task automatic set_exp(input logic [1:0] rv, err, chkm, input logic [31:0] r0, r1);
        e_rv = rv; e_err = err; e_chk = chkm; e_rd[0] = r0; e_rd[1] = r1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(2'b10, 2'b10, 0, 32'h40, 0, 4'hF, 0, 32'hCAFE_F00D, 2'b10, 0, 0, 2'b10, 2'b00);
        tbl[1]  = mk(2'b10, 2'b00, 0, 32'h40, 0, 0, 0, 0, 2'b10, 0, 32'hCAFE_F00D, 2'b10, 2'b00);
        tbl[2]  = mk(2'b01, 2'b01, 32'h80, 0, 4'hF, 0, 32'hFFFF_FFFF, 0, 2'b01, 0, 0, 2'b01, 2'b00);
        tbl[3]  = mk(2'b01, 2'b01, 32'h80, 0, 4'b0101, 0, 32'h1122_3344, 0, 2'b01, 0, 0, 2'b01, 2'b00);
        tbl[4]  = mk(2'b10, 2'b00, 0, 32'h80, 0, 0, 0, 0, 2'b10, 0, 32'hFF22_FF44, 2'b10, 2'b00);
        tbl[5]  = mk(2'b11, 2'b00, 32'h0C, 32'h4C, 0, 0, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00);
        tbl[6]  = mk(2'b11, 2'b00, 32'h0C, 32'h4C, 0, 0, 0, 0, 2'b10, 0, 0, 2'b00, 2'b00);
        tbl[7]  = mk(2'b11, 2'b00, 32'h0C, 32'h4C, 0, 0, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00);
        tbl[8]  = mk(2'b11, 2'b00, 32'h0C, 32'h4C, 0, 0, 0, 0, 2'b10, 0, 0, 2'b00, 2'b00);
        tbl[9]  = mk(2'b11, 2'b11, 32'h00, 32'h04, 4'hF, 4'hF, 32'hA5A5_0000, 32'h5A5A_0004,
                     2'b11, 0, 0, 2'b11, 2'b00);
        tbl[10] = mk(2'b11, 2'b00, 32'h04, 32'h00, 0, 0, 0, 0, 2'b11,
                     32'h5A5A_0004, 32'hA5A5_0000, 2'b11, 2'b00);
        tbl[11] = mk(2'b10, 2'b00, 0, 32'h0001_0000, 0, 0, 0, 0, 2'b10, 0, 0, 2'b10, 2'b10);
        tbl[12] = mk(2'b10, 2'b10, 0, 32'h0001_0000, 0, 4'hF, 0, 32'hDEAD_BEEF, 2'b10, 0, 0, 2'b10, 2'b10);
        tbl[13] = mk(2'b10, 2'b00, 0, 32'h00, 0, 0, 0, 0, 2'b10, 0, 32'hA5A5_0000, 2'b10, 2'b00);
        tbl[14] = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);

        // Reset: requests are present but must never be granted.
        rst = 1'b1;
        drive(2'b11, 2'b11, 32'h0, 32'h4, 4'hF, 4'hF, 32'h0BAD_0BAD, 32'h0BAD_0BAD);
        #3;
        chk("reset gnt", 32'(bus.gnt_o), 32'h0);
        next_cycle();
        chk("reset gnt 2", 32'(bus.gnt_o), 32'h0);
        next_cycle();
        rst = 1'b0;
        set_exp(2'b00, 2'b00, 2'b00, 0, 0);

        // Directed vectors.
        for (int i = 0; i < 15; i++) begin
            check_resp($sformatf("vec%0d", i));
            drive(tbl[i].req, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].b0, tbl[i].b1, tbl[i].d0, tbl[i].d1);
            #3;
            chk($sformatf("vec%0d gnt", i), 32'(bus.gnt_o), 32'(tbl[i].gnt));
            set_exp(tbl[i].gnt, tbl[i].err, tbl[i].chk, tbl[i].r0, tbl[i].r1);
            next_cycle();
        end

        // Reset during a grant: move rr of bank 3 to port 1 first.
        check_resp("pre_rst");
        drive(2'b11, 2'b00, 32'h0C, 32'h4C, 0, 0, 0, 0);
        #3;
        chk("pre_rst gnt", 32'(bus.gnt_o), 32'h1);
        set_exp(2'b01, 2'b00, 2'b00, 0, 0);
        next_cycle();
        check_resp("rst_cycle");
        rst = 1'b1;
        drive(2'b11, 2'b01, 32'h00, 32'h4C, 4'hF, 0, 32'h1234_5678, 0);
        #3;
        chk("rst_cycle gnt", 32'(bus.gnt_o), 32'h0);
        set_exp(2'b00, 2'b00, 2'b00, 0, 0);
        next_cycle();
        rst = 1'b0;
        check_resp("post_rst");
        drive(2'b11, 2'b00, 32'h0C, 32'h4C, 0, 0, 0, 0);
        #3;
        chk("post_rst rr gnt", 32'(bus.gnt_o), 32'h1);
        set_exp(2'b01, 2'b00, 2'b00, 0, 0);
        next_cycle();
        check_resp("post_rst resp");
        drive(2'b01, 2'b00, 32'h00, 32'h00, 0, 0, 0, 0);
        #3;
        chk("rst_nowrite gnt", 32'(bus.gnt_o), 32'h1);
        set_exp(2'b01, 2'b00, 2'b01, 32'hA5A5_0000, 0);
        next_cycle();
        check_resp("rst_nowrite");

        // Random traffic against the model; fresh reset so pointers are known.
        rst = 1'b1;
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        next_cycle();
        rst = 1'b0;
        set_exp(2'b00, 2'b00, 2'b00, 0, 0);
        for (int b = 0; b < NB; b++) rr_m[b] = 0;
        for (int p = 0; p < NP; p++) pd[p].act = 1'b0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [1:0] exp_g;
            check_resp("rnd");
            for (int p = 0; p < NP; p++) begin
                if (!pd[p].act && $urandom_range(0, 9) < 7) begin
                    int w;
                    w = ($urandom_range(0, 9) == 0) ? 16384 + int'($urandom_range(0, 63))
                                                    : int'($urandom_range(0, 47));
                    pd[p].act   = 1'b1;
                    pd[p].we    = 1'($urandom_range(0, 1));
                    pd[p].addr  = 32'(w * 4) + 32'($urandom_range(0, 3));
                    pd[p].be    = 4'($urandom);
                    pd[p].wdata = $urandom;
                end
            end
            drive({pd[1].act, pd[0].act}, {pd[1].we, pd[0].we}, pd[0].addr, pd[1].addr,
                  pd[0].be, pd[1].be, pd[0].wdata, pd[1].wdata);

            // Each bank serves the first port, scanning cyclically from its pointer.
            exp_g = 2'b00;
            for (int b = 0; b < NB; b++) begin
                int win;
                win = -1;
                for (int k = 0; k < NP; k++) begin
                    int p;
                    p = (rr_m[b] + k) % NP;
                    if (win < 0 && pd[p].act && (((pd[p].addr >> 2) % NB) == b)) win = p;
                end
                if (win >= 0) begin
                    exp_g[win] = 1'b1;
                    rr_m[b] = (win + 1) % NP;
                end
            end
            #3;
            chk("rnd gnt", 32'(bus.gnt_o), 32'(exp_g));

            set_exp(exp_g, 2'b00, 2'b00, 0, 0);
            for (int p = 0; p < NP; p++) begin
                if (exp_g[p]) begin
                    int  word;
                    bit  oor;
                    word = int'(pd[p].addr >> 2);
                    oor  = (word / NB) >= NW;
                    e_err[p] = oor;
                    if (pd[p].we || oor) begin
                        e_chk[p] = 1'b1;
                        e_rd[p]  = 32'h0;
                    end else if (mem_m.exists(word)) begin
                        e_chk[p] = 1'b1;
                        e_rd[p]  = mem_m[word];
                    end
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (exp_g[p]) begin
                    int word;
                    word = int'(pd[p].addr >> 2);
                    if (pd[p].we && (word / NB) < NW) begin
                        if (mem_m.exists(word)) begin
                            logic [31:0] v;
                            v = mem_m[word];
                            for (int i = 0; i < 4; i++)
                                if (pd[p].be[i]) v[8*i +: 8] = pd[p].wdata[8*i +: 8];
                            mem_m[word] = v;
                        end else if (pd[p].be == 4'hF) begin
                            mem_m[word] = pd[p].wdata;
                        end
                    end
                    pd[p].act = 1'b0;
                end
            end
            next_cycle();
        end
        check_resp("rnd last");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
